// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - dual-channel double-buffered servo PWM generator (optional watchdog: SERVO_PWM_WDOG_EN)
module servo_pwm_gen #(
    parameter int FRAME_CYCLES  = 1000000,
    parameter int MIN_PULSE     = 10000,
    parameter int MAX_PULSE     = 60000,
    parameter int NEUTRAL_PULSE = 35000,
    parameter int WDOG_FRAMES   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        update,
    input  logic [15:0] pulse_L_in,
    input  logic [15:0] pulse_R_in,
    output logic        pwm_L,
    output logic        pwm_R,
    output logic        frame_tick,
    output logic        active,
    output logic        wdog_trip
);

    localparam int CW   = $clog2(FRAME_CYCLES);
    localparam int CMPW = (CW > 16) ? CW : 16;
    localparam int WDW  = $clog2(WDOG_FRAMES + 1);

    localparam logic [CW-1:0]  LAST_CNT  = CW'(FRAME_CYCLES - 1);
    localparam logic [15:0]    MIN16     = 16'(MIN_PULSE);
    localparam logic [15:0]    MAX16     = 16'(MAX_PULSE);
    localparam logic [15:0]    NEUTRAL16 = 16'(NEUTRAL_PULSE);
    localparam logic [WDW-1:0] WDOG_LIM  = WDW'(WDOG_FRAMES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [15:0]    shad_l_q, shad_l_d, shad_r_q, shad_r_d;
    logic           pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
    logic           tick_q, tick_d;
    logic           trip_q, trip_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           reload;
    logic           frame_wrap;
    logic           at_last;

    function automatic logic [15:0] clamp(input logic [15:0] v);
        if (v < MIN16) begin
            return MIN16;
        end else if (v > MAX16) begin
            return MAX16;
        end
        return v;
    endfunction

    assign at_last = (cnt_q == LAST_CNT);

    // Frame sequencer: state, frame counter, reload strobe and frame tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reload  = 1'b0;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                    reload  = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                if (at_last) begin
                    cnt_d  = '0;
                    reload = 1'b1;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (at_last) begin
                    cnt_d = '0;
                    if (enable) begin
                        // Re-armed before the wrap: behave exactly as if RUN had never been left.
                        state_d = RUN;
                        reload  = 1'b1;
                        tick_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (enable) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign frame_wrap = reload && (state_q != IDLE);

    // Shadow widths follow the pending words only at frame boundaries; PWM is precomputed from next state.
    always_comb begin
        shad_l_d = reload ? pend_l_q : shad_l_q;
        shad_r_d = reload ? pend_r_q : shad_r_q;
        pwm_l_d  = (state_d != IDLE) && (CMPW'(cnt_d) < CMPW'(shad_l_d));
        pwm_r_d  = (state_d != IDLE) && (CMPW'(cnt_d) < CMPW'(shad_r_d));
    end

    // Pending-word capture, frames-since-update counter and watchdog override (update has priority).
    always_comb begin
        pend_l_d = pend_l_q;
        pend_r_d = pend_r_q;
        wdog_d   = wdog_q;
        trip_d   = trip_q;
        if (frame_wrap && (wdog_q != WDOG_LIM)) begin
            wdog_d = wdog_q + 1'b1;
`ifdef SERVO_PWM_WDOG_EN
            if (wdog_d == WDOG_LIM) begin
                pend_l_d = NEUTRAL16;
                pend_r_d = NEUTRAL16;
                trip_d   = 1'b1;
            end
`endif
        end
        if (update) begin
            pend_l_d = clamp(pulse_L_in);
            pend_r_d = clamp(pulse_R_in);
            wdog_d   = '0;
            trip_d   = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset to the neutral, idle condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_l_q <= NEUTRAL16;
            pend_r_q <= NEUTRAL16;
            shad_l_q <= NEUTRAL16;
            shad_r_q <= NEUTRAL16;
            pwm_l_q  <= 1'b0;
            pwm_r_q  <= 1'b0;
            tick_q   <= 1'b0;
            trip_q   <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            shad_l_q <= shad_l_d;
            shad_r_q <= shad_r_d;
            pwm_l_q  <= pwm_l_d;
            pwm_r_q  <= pwm_r_d;
            tick_q   <= tick_d;
            trip_q   <= trip_d;
            wdog_q   <= wdog_d;
        end
    end

    assign pwm_L      = pwm_l_q;
    assign pwm_R      = pwm_r_q;
    assign frame_tick = tick_q;
    assign active     = (state_q != IDLE);
    assign wdog_trip  = trip_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - directed self-checking bench for servo_pwm_gen
module tb_servo_pwm_gen;

    localparam int F   = 200;
    localparam int MNP = 20;
    localparam int MXP = 120;
    localparam int NEU = 70;
    localparam int WDF = 5;

    logic        clk = 1'b0;
    logic        rst_n, enable, update;
    logic [15:0] pl, pr;
    logic        pwm_L, pwm_R, frame_tick, active, wdog_trip;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    servo_pwm_gen #(
        .FRAME_CYCLES(F), .MIN_PULSE(MNP), .MAX_PULSE(MXP),
        .NEUTRAL_PULSE(NEU), .WDOG_FRAMES(WDF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .update(update),
        .pulse_L_in(pl), .pulse_R_in(pr),
        .pwm_L(pwm_L), .pwm_R(pwm_R), .frame_tick(frame_tick),
        .active(active), .wdog_trip(wdog_trip)
    );

    // Advance negedge by negedge until frame_tick is seen; waited = cycles taken, 0 on timeout.
    task automatic wait_tick(output int waited);
        waited = 0;
        for (int i = 1; i <= 3 * F; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                waited = i;
                break;
            end
        end
    endtask

    // Observe one whole frame starting at its tick cycle; ends on the negedge of the last cycle.
    task automatic measure_frame(input bit at_tick, output int waited, output int hl, output int hr,
                                 output int tk, output int rl);
        logic prev;
        if (at_tick) waited = 1;
        else wait_tick(waited);
        hl = 0; hr = 0; tk = 0; rl = 0; prev = 1'b0;
        for (int i = 0; i < F; i++) begin
            if (pwm_L) hl++;
            if (pwm_R) hr++;
            if (frame_tick) tk++;
            if (pwm_L && !prev) rl++;
            prev = pwm_L;
            if (i < F - 1) @(negedge clk);
        end
    endtask

    task automatic do_update(input int l, input int r);
        @(negedge clk);
        update = 1'b1; pl = 16'(l); pr = 16'(r);
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; update = 1'b0; pl = '0; pr = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (pwm_L !== 1'b0) begin n_err++; $display("FAIL reset_pwm_L got=%b exp=0", pwm_L); end
        n_cmp++; if (pwm_R !== 1'b0) begin n_err++; $display("FAIL reset_pwm_R got=%b exp=0", pwm_R); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active got=%b exp=0", active); end
        n_cmp++; if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL reset_wdog got=%b exp=0", wdog_trip); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL idle_after_reset got=%b exp=0", active); end
    endtask

    task automatic test_neutral;
        int w, hl, hr, tk, rl, t;
        enable = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({active, frame_tick, pwm_L, pwm_R} !== 4'b1111) begin
            n_err++; $display("FAIL start_latency got=%b exp=1111", {active, frame_tick, pwm_L, pwm_R});
        end
        measure_frame(1'b1, w, hl, hr, tk, rl);
        n_cmp++; if (hl !== NEU) begin n_err++; $display("FAIL neutral_L1 got=%0d exp=%0d", hl, NEU); end
        n_cmp++; if (hr !== NEU) begin n_err++; $display("FAIL neutral_R1 got=%0d exp=%0d", hr, NEU); end
        n_cmp++; if (tk !== 1) begin n_err++; $display("FAIL neutral_ticks got=%0d exp=1", tk); end
        n_cmp++; if (rl !== 1) begin n_err++; $display("FAIL neutral_edges got=%0d exp=1", rl); end
        measure_frame(1'b0, w, hl, hr, tk, rl);
        n_cmp++; if (w !== 1) begin n_err++; $display("FAIL tick_spacing got=%0d exp=1", w); end
        n_cmp++; if (hl !== NEU) begin n_err++; $display("FAIL neutral_L2 got=%0d exp=%0d", hl, NEU); end
        n_cmp++; if (hr !== NEU) begin n_err++; $display("FAIL neutral_R2 got=%0d exp=%0d", hr, NEU); end
        enable = 1'b0;
        t = 0;
        for (int i = 0; i < 3 * F; i++) begin
            @(negedge clk);
            if (!active) begin t = 1; break; end
        end
        n_cmp++; if (t !== 1) begin n_err++; $display("FAIL stop_to_idle got=%0d exp=1", t); end
    endtask

    task automatic test_idle_capture;
        int w, hl, hr, tk, rl, busy;
        do_update(60, 100);
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (pwm_L || pwm_R || frame_tick || active) busy++;
        end
        n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL idle_quiet got=%0d exp=0", busy); end
        enable = 1'b1;
        @(negedge clk);
        n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL idle_start_tick got=%b exp=1", frame_tick); end
        measure_frame(1'b1, w, hl, hr, tk, rl);
        n_cmp++; if (hl !== 60) begin n_err++; $display("FAIL idle_cap_L got=%0d exp=60", hl); end
        n_cmp++; if (hr !== 100) begin n_err++; $display("FAIL idle_cap_R got=%0d exp=100", hr); end
    endtask

    task automatic test_clamp;
        int in_l[4]  = '{5, 19, 20, 21};
        int in_r[4]  = '{65535, 121, 120, 119};
        int exp_l[4] = '{20, 20, 20, 21};
        int exp_r[4] = '{120, 120, 120, 119};
        int w, hl, hr, tk, rl;
        for (int k = 0; k < 4; k++) begin
            wait_tick(w);
            repeat (5) @(negedge clk);
            do_update(in_l[k], in_r[k]);
            measure_frame(1'b0, w, hl, hr, tk, rl);
            n_cmp++; if (hl !== exp_l[k]) begin n_err++; $display("FAIL clamp_L[%0d] got=%0d exp=%0d", k, hl, exp_l[k]); end
            n_cmp++; if (hr !== exp_r[k]) begin n_err++; $display("FAIL clamp_R[%0d] got=%0d exp=%0d", k, hr, exp_r[k]); end
        end
    endtask

    task automatic test_back_to_back;
        int w, hl, hr, tk, rl;
        wait_tick(w);
        hl = 0;
        for (int i = 0; i < F; i++) begin
            if (pwm_L) hl++;
            if (i == 100) begin update = 1'b1; pl = 16'd50; pr = 16'd100; end
            if (i == 101) update = 1'b0;
            if (i == F - 1) begin update = 1'b1; pl = 16'd90; end
            if (i < F - 1) @(negedge clk);
        end
        @(negedge clk);
        update = 1'b0;
        n_cmp++; if (hl !== 21) begin n_err++; $display("FAIL b2b_current got=%0d exp=21", hl); end
        measure_frame(1'b1, w, hl, hr, tk, rl);
        n_cmp++; if (hl !== 50) begin n_err++; $display("FAIL b2b_next_L got=%0d exp=50", hl); end
        n_cmp++; if (hr !== 100) begin n_err++; $display("FAIL b2b_next_R got=%0d exp=100", hr); end
        measure_frame(1'b0, w, hl, hr, tk, rl);
        n_cmp++; if (hl !== 90) begin n_err++; $display("FAIL b2b_later_L got=%0d exp=90", hl); end
    endtask

    task automatic test_drain;
        int w, hl, hr, tk, rl, lows, quiet;
        wait_tick(w);
        hl = 0; hr = 0; lows = 0;
        for (int i = 0; i < F; i++) begin
            if (pwm_L) hl++;
            if (pwm_R) hr++;
            if (!active) lows++;
            if (i == 10) enable = 1'b0;
            if (i < F - 1) @(negedge clk);
        end
        n_cmp++; if (hl !== 90) begin n_err++; $display("FAIL drain_L got=%0d exp=90", hl); end
        n_cmp++; if (hr !== 100) begin n_err++; $display("FAIL drain_R got=%0d exp=100", hr); end
        n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL drain_active got=%0d exp=0", lows); end
        @(negedge clk);
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL drain_end_active got=%b exp=0", active); end
        quiet = 0;
        repeat (F + 50) begin
            if (pwm_L || pwm_R || frame_tick) quiet++;
            @(negedge clk);
        end
        n_cmp++; if (quiet !== 0) begin n_err++; $display("FAIL drain_quiet got=%0d exp=0", quiet); end
        enable = 1'b1;
        @(negedge clk);
        n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL rearm_tick got=%b exp=1", frame_tick); end
        hl = 0; lows = 0;
        for (int i = 0; i < F; i++) begin
            if (pwm_L) hl++;
            if (!active) lows++;
            if (i == 10) enable = 1'b0;
            if (i == 50) enable = 1'b1;
            if (i < F - 1) @(negedge clk);
        end
        n_cmp++; if (hl !== 90) begin n_err++; $display("FAIL rearm_L got=%0d exp=90", hl); end
        n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL rearm_active got=%0d exp=0", lows); end
        measure_frame(1'b0, w, hl, hr, tk, rl);
        n_cmp++; if (w !== 1) begin n_err++; $display("FAIL rearm_gap got=%0d exp=1", w); end
        n_cmp++; if (hl !== 90) begin n_err++; $display("FAIL rearm_next_L got=%0d exp=90", hl); end
    endtask

    task automatic test_reset_mid;
        int w, hl, hr, tk, rl;
        wait_tick(w);
        repeat (30) @(negedge clk);
        n_cmp++; if (pwm_L !== 1'b1) begin n_err++; $display("FAIL mid_pre_pwm got=%b exp=1", pwm_L); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({pwm_L, pwm_R, active} !== 3'b000) begin n_err++; $display("FAIL mid_reset_async got=%b exp=000", {pwm_L, pwm_R, active}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL mid_restart_tick got=%b exp=1", frame_tick); end
        measure_frame(1'b1, w, hl, hr, tk, rl);
        n_cmp++; if (hl !== NEU) begin n_err++; $display("FAIL mid_full_L got=%0d exp=%0d", hl, NEU); end
        n_cmp++; if (hr !== NEU) begin n_err++; $display("FAIL mid_full_R got=%0d exp=%0d", hr, NEU); end
    endtask

    task automatic test_wdog;
        int w, hl, hr, tk, rl, exp6;
        logic exp_trip;
`ifdef SERVO_PWM_WDOG_EN
        exp_trip = 1'b1; exp6 = NEU;
`else
        exp_trip = 1'b0; exp6 = 110;
`endif
        wait_tick(w);
        repeat (5) @(negedge clk);
        do_update(110, 110);
        for (int k = 1; k <= WDF; k++) begin
            measure_frame(1'b0, w, hl, hr, tk, rl);
            n_cmp++; if (hl !== 110) begin n_err++; $display("FAIL wdog_frame%0d got=%0d exp=110", k, hl); end
        end
        n_cmp++; if (wdog_trip !== exp_trip) begin n_err++; $display("FAIL wdog_trip got=%b exp=%b", wdog_trip, exp_trip); end
        measure_frame(1'b0, w, hl, hr, tk, rl);
        n_cmp++; if (hl !== exp6) begin n_err++; $display("FAIL wdog_after got=%0d exp=%0d", hl, exp6); end
        do_update(40, 40);
        n_cmp++; if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL wdog_clear got=%b exp=0", wdog_trip); end
    endtask

    initial begin
        test_reset;
        test_neutral;
        test_idle_capture;
        test_clamp;
        test_back_to_back;
        test_drain;
        test_reset_mid;
        test_wdog;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
